// File: rtl/cpu_pkg.sv
// Shared core definitions: opcode constants, condition codes and the fixed
// instruction words used by the fetch stage and the decoder.
package cpu_pkg;

  localparam logic [1:0]  FLD_CTRL = 2'b11;

  localparam logic [6:0]  OP_B     = 7'b1100000;
  localparam logic [6:0]  OP_BCOND = 7'b1100001;
  localparam logic [6:0]  OP_BR    = 7'b1100010;
  localparam logic [6:0]  OP_NOP   = 7'b1100100;
  localparam logic [6:0]  OP_HALT  = 7'b1101000;

  localparam logic [31:0] NOP_WORD  = 32'hC800_0000;
  localparam logic [31:0] HALT_WORD = 32'hD000_0000;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
    COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
    COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
    COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
  } cond_e;

  typedef enum logic {
    S_RUN    = 1'b0,
    S_HALTED = 1'b1
  } fetch_state_e;

  function automatic logic is_ctrl_op(input logic [6:0] op);
    return op[6:5] == FLD_CTRL;
  endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational condition-code evaluator for conditional branches.
// flags are packed {N,Z,C,V}.
module branch_cond_eval
  import cpu_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       taken
);

  logic n, z, c, v;

  always_comb begin
    {n, z, c, v} = flags;
    taken = 1'b0;
    case (cond_e'(cond))
      COND_EQ: taken = z;
      COND_NE: taken = !z;
      COND_CS: taken = c;
      COND_CC: taken = !c;
      COND_MI: taken = n;
      COND_PL: taken = !n;
      COND_VS: taken = v;
      COND_VC: taken = !v;
      COND_HI: taken = c && !z;
      COND_LS: taken = !c || z;
      COND_GE: taken = (n == v);
      COND_LT: taken = (n != v);
      COND_GT: taken = !z && (n == v);
      COND_LE: taken = z || (n != v);
      COND_AL: taken = 1'b1;
      COND_NV: taken = 1'b0;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, resolves control-class instructions
// locally and forwards data/memory instructions to the decoder.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       instr,
  output logic              instr_valid,
  output logic [2:0]        br_reg_addr,
  input  logic [31:0]       br_reg_data,
  input  logic [3:0]        flags,
  input  logic              stall,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic              illegal,
  output logic [31:0]       issue_count
);

  fetch_state_e      state, state_next;
  logic [ADDR_W-1:0] pc_next;
  logic              illegal_next;
  logic [6:0]        op;
  logic              ctrl;
  logic              active;
  logic              taken;
  logic [31:0]       off32;
  logic [ADDR_W-1:0] off;
  logic [ADDR_W-1:0] pc_inc;
  logic              unused_br;

  assign op          = imem_rdata[31:25];
  assign ctrl        = is_ctrl_op(op);
  assign off32       = {{16{imem_rdata[15]}}, imem_rdata[15:0]};
  assign off         = off32[ADDR_W-1:0];
  assign pc_inc      = pc + ADDR_W'(1);
  assign active      = (state == S_RUN) && !stall;
  assign imem_addr   = pc;
  assign br_reg_addr = imem_rdata[24:22];
  // Only the low ADDR_W bits of the pointer register form a branch target.
  assign unused_br   = ^br_reg_data;

  branch_cond_eval u_cond (
    .cond  (imem_rdata[24:21]),
    .flags (flags),
    .taken (taken)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_RUN;
      pc          <= RESET_PC;
      illegal     <= 1'b0;
      issue_count <= '0;
    end else begin
      state   <= state_next;
      pc      <= pc_next;
      illegal <= illegal_next;
      if (active)
        issue_count <= issue_count + 32'd1;
    end
  end

  always_comb begin
    state_next   = state;
    pc_next      = pc;
    illegal_next = 1'b0;
    if (active) begin
      pc_next = pc_inc;
      if (ctrl) begin
        case (op)
          OP_B:     pc_next = pc + off;
          OP_BCOND: pc_next = taken ? pc + off : pc_inc;
          OP_BR:    pc_next = br_reg_data[ADDR_W-1:0] + off;
          OP_NOP:   pc_next = pc_inc;
          OP_HALT: begin
            pc_next    = pc;
            state_next = S_HALTED;
          end
          default:  illegal_next = 1'b1;
        endcase
      end
    end
  end

  always_comb begin
    halted      = (state == S_HALTED);
    instr_valid = active && !ctrl;
    instr       = instr_valid ? imem_rdata : NOP_WORD;
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: walks a hand-laid program through an
// asynchronous-read instruction memory and checks PC, outputs and counters.
module tb_instr_fetch;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [2:0]  br_reg_addr;
  logic [31:0] br_reg_data;
  logic [3:0]  flags;
  logic        stall;
  logic [15:0] pc;
  logic        halted;
  logic        illegal;
  logic [31:0] issue_count;

  logic [31:0] mem [0:65535];
  int unsigned total = 0;
  int unsigned bad   = 0;

  localparam logic [31:0] ADD_WORD = 32'h0286_0000;

  always #5 clk = ~clk;
  assign imem_rdata = mem[imem_addr];

  instr_fetch #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .br_reg_addr (br_reg_addr),
    .br_reg_data (br_reg_data),
    .flags       (flags),
    .stall       (stall),
    .pc          (pc),
    .halted      (halted),
    .illegal     (illegal),
    .issue_count (issue_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = ADD_WORD;
    mem[10]    = 32'hC000_FFFC; // B -4
    mem[6]     = 32'hC200_0014; // Bcond EQ +20
    mem[26]    = 32'hC200_0014; // Bcond EQ +20
    mem[27]    = 32'hC380_000A; // Bcond GT +10
    mem[37]    = 32'hC3A0_000A; // Bcond LE +10
    mem[38]    = 32'hC540_0002; // BR r5 +2
    mem[16'h42] = 32'hC000_0005; // B +5
    mem[16'h47] = 32'hE000_0000; // undefined control op
    mem[16'h49] = 32'hC000_FFB6; // B to 0xFFFF
    mem[16'hFFFF] = NOP_WORD;

    rst = 1'b1; stall = 1'b0; flags = 4'b0000; br_reg_data = 32'h0001_0040;
    tick(2);
    rst = 1'b0;

    // reset state and straight-line fetch
    chk("rst_pc", pc, 32'd0);
    chk("rst_halted", halted, 32'd0);
    chk("rst_illegal", illegal, 32'd0);
    chk("rst_count", issue_count, 32'd0);
    chk("add_valid", instr_valid, 32'd1);
    chk("add_instr", instr, ADD_WORD);
    chk("imem_addr", imem_addr, 32'd0);
    tick(1); chk("pc1", pc, 32'd1);
    tick(1); chk("pc2", pc, 32'd2);
    chk("valid2", instr_valid, 32'd1);
    tick(1); chk("pc3", pc, 32'd3);
    chk("count3", issue_count, 32'd3);

    // backward branch
    tick(7);
    chk("pc10", pc, 32'd10);
    chk("b_valid", instr_valid, 32'd0);
    chk("b_instr", instr, NOP_WORD);
    tick(1); chk("b_pc", pc, 32'd6);

    // conditional branches
    flags = 4'b0100;
    tick(1); chk("eq_taken", pc, 32'd26);
    flags = 4'b0000;
    tick(1); chk("eq_not", pc, 32'd27);
    flags = 4'b1001;
    tick(1); chk("gt_taken", pc, 32'd37);
    tick(1); chk("le_not", pc, 32'd38);

    // register-indirect branch
    chk("br_addr", br_reg_addr, 32'd5);
    tick(1); chk("br_pc", pc, 32'h42);
    chk("count_br", issue_count, 32'd16);

    // stall over a taken branch
    stall = 1'b1;
    tick(2);
    chk("stall_pc", pc, 32'h42);
    chk("stall_count", issue_count, 32'd16);
    chk("stall_valid", instr_valid, 32'd0);
    stall = 1'b0;
    tick(1); chk("unstall_b", pc, 32'h47);

    // undefined control op
    tick(1);
    chk("ill_pc", pc, 32'h48);
    chk("ill_pulse", illegal, 32'd1);
    tick(1);
    chk("ill_clear", illegal, 32'd0);
    chk("ill_next_pc", pc, 32'h49);

    // PC wrap through NOP at top of memory
    tick(1); chk("pc_ffff", pc, 32'hFFFF);
    tick(1); chk("wrap_pc", pc, 32'd0);
    chk("count_wrap", issue_count, 32'd21);

    // halt and its persistence
    mem[6] = ADD_WORD;
    mem[7] = HALT_WORD;
    tick(7); chk("pc7", pc, 32'd7);
    tick(1);
    chk("halted", halted, 32'd1);
    chk("halt_pc", pc, 32'd7);
    chk("halt_count", issue_count, 32'd29);
    stall = 1'b1; tick(1);
    stall = 1'b0; tick(2);
    chk("halt_hold_pc", pc, 32'd7);
    chk("halt_hold_cnt", issue_count, 32'd29);
    chk("halt_valid", instr_valid, 32'd0);
    chk("halt_instr", instr, NOP_WORD);

    // reset leaves the halted state
    rst = 1'b1; tick(1); rst = 1'b0;
    chk("rst2_pc", pc, 32'd0);
    chk("rst2_halted", halted, 32'd0);
    chk("rst2_count", issue_count, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
